// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage issuing data-memory req/ack accesses and registering MEM/WB outputs.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int RD_W           = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              IRegWrite,
    input  logic              IMemRead,
    input  logic              IMemWrite,
    input  logic              IRegStore,
    input  logic [DATA_W-1:0] IALUResult,
    input  logic [DATA_W-1:0] I3rdArg,
    input  logic [RD_W-1:0]   IRd,
    output logic              DmemReq,
    output logic              DmemWe,
    output logic [ADDR_W-1:0] DmemAddr,
    output logic [DATA_W-1:0] DmemWData,
    input  logic [DATA_W-1:0] DmemRData,
    input  logic              DmemAck,
    output logic              Stall,
    output logic              ORegWrite,
    output logic              ORegStore,
    output logic [DATA_W-1:0] OResult,
    output logic [RD_W-1:0]   ORd,
    output logic              OMemErr
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_n;
    logic              mem_op;
    logic              req_n, we_n, rw_n, rs_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n, res_n;
    logic [RD_W-1:0]   rd_n;
    logic              l_rw, l_rs, l_load, l_rw_n, l_rs_n, l_load_n;
    logic [DATA_W-1:0] l_alu, l_alu_n;
    logic [RD_W-1:0]   l_rd, l_rd_n;
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt, cnt_n;
    logic          err_n;
`endif
    assign mem_op = IMemRead | IMemWrite;
    assign Stall  = (state == REQ) || (state == IDLE && mem_op);
    always_comb begin
        state_n  = state;
        req_n    = DmemReq;
        we_n     = DmemWe;
        addr_n   = DmemAddr;
        wdata_n  = DmemWData;
        rw_n     = ORegWrite;
        rs_n     = ORegStore;
        res_n    = OResult;
        rd_n     = ORd;
        l_rw_n   = l_rw;
        l_rs_n   = l_rs;
        l_load_n = l_load;
        l_alu_n  = l_alu;
        l_rd_n   = l_rd;
`ifdef MEM_TIMEOUT_EN
        cnt_n    = cnt;
        err_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (mem_op) begin
                    state_n  = REQ;
                    req_n    = 1'b1;
                    we_n     = IMemWrite;
                    addr_n   = IALUResult[ADDR_W-1:0];
                    wdata_n  = I3rdArg;
                    rw_n     = 1'b0;
                    l_rw_n   = IRegWrite;
                    l_rs_n   = IRegStore;
                    l_rd_n   = IRd;
                    l_alu_n  = IALUResult;
                    l_load_n = IMemRead & ~IMemWrite;
`ifdef MEM_TIMEOUT_EN
                    cnt_n    = '0;
`endif
                end else begin
                    rw_n  = IRegWrite;
                    rs_n  = IRegStore;
                    res_n = IALUResult;
                    rd_n  = IRd;
                end
            end
            REQ: begin
                rw_n = 1'b0;
                if (DmemAck) begin
                    state_n = DONE;
                    req_n   = 1'b0;
                    res_n   = l_load ? DmemRData : l_alu;
                    rw_n    = l_rw;
                    rs_n    = l_rs;
                    rd_n    = l_rd;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = DONE;
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                    res_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            DONE: begin
                // EX/MEM advances on this edge; the held instruction already completed.
                state_n = IDLE;
                rw_n    = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            DmemReq   <= 1'b0;
            DmemWe    <= 1'b0;
            DmemAddr  <= '0;
            DmemWData <= '0;
            ORegWrite <= 1'b0;
            ORegStore <= 1'b0;
            OResult   <= '0;
            ORd       <= '0;
            l_rw      <= 1'b0;
            l_rs      <= 1'b0;
            l_load    <= 1'b0;
            l_alu     <= '0;
            l_rd      <= '0;
        end else begin
            state     <= state_n;
            DmemReq   <= req_n;
            DmemWe    <= we_n;
            DmemAddr  <= addr_n;
            DmemWData <= wdata_n;
            ORegWrite <= rw_n;
            ORegStore <= rs_n;
            OResult   <= res_n;
            ORd       <= rd_n;
            l_rw      <= l_rw_n;
            l_rs      <= l_rs_n;
            l_load    <= l_load_n;
            l_alu     <= l_alu_n;
            l_rd      <= l_rd_n;
        end
    end
`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt     <= '0;
            OMemErr <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            OMemErr <= err_n;
        end
    end
`else
    assign OMemErr = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
// Define MEM_TIMEOUT_EN for both files to exercise the ack watchdog.
module tb_mem_access_stage;
    logic        CLK = 1'b0, Reset = 1'b1;
    logic        IRegWrite, IMemRead, IMemWrite, IRegStore;
    logic [15:0] IALUResult, I3rdArg, IRd;
    logic        DmemReq, DmemWe, DmemAck;
    logic [15:0] DmemAddr, DmemWData, DmemRData;
    logic        Stall, ORegWrite, ORegStore, OMemErr;
    logic [15:0] OResult, ORd;
    int          vec = 0, errs = 0;
    int          nreq = 0, nhigh = 0;
    logic        req_d = 1'b0;
    logic [15:0] alog[$];

    mem_access_stage #(.DATA_W(16), .ADDR_W(16), .RD_W(16), .TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .Reset(Reset), .IRegWrite(IRegWrite), .IMemRead(IMemRead),
        .IMemWrite(IMemWrite), .IRegStore(IRegStore), .IALUResult(IALUResult),
        .I3rdArg(I3rdArg), .IRd(IRd), .DmemReq(DmemReq), .DmemWe(DmemWe),
        .DmemAddr(DmemAddr), .DmemWData(DmemWData), .DmemRData(DmemRData),
        .DmemAck(DmemAck), .Stall(Stall), .ORegWrite(ORegWrite), .ORegStore(ORegStore),
        .OResult(OResult), .ORd(ORd), .OMemErr(OMemErr)
    );

    always #5 CLK = ~CLK;

    // Request monitor: counts request issues and high cycles, logs issued addresses.
    always @(negedge CLK) begin
        if (DmemReq === 1'b1) begin
            nhigh++;
            if (req_d !== 1'b1) begin
                nreq++;
                alog.push_back(DmemAddr);
            end
        end
        req_d = DmemReq;
    end

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic drive(input logic rw, rd, wr, rs, input logic [15:0] alu, arg, dst);
        IRegWrite = rw; IMemRead = rd; IMemWrite = wr; IRegStore = rs;
        IALUResult = alu; I3rdArg = arg; IRd = dst;
        #1;
    endtask

    task automatic test_reset;
        DmemAck = 1'b0; DmemRData = 16'h0;
        drive(1, 0, 0, 0, 16'h1234, 16'h0, 16'd3);
        tick; tick;
        vec++; if ({DmemReq, DmemWe, DmemAddr, DmemWData, ORegWrite, ORegStore, OResult, ORd, OMemErr} !== 69'h0) begin errs++; $display("FAIL reset_outs: got %h want 0", {DmemReq, DmemWe, DmemAddr, DmemWData, ORegWrite, ORegStore, OResult, ORd, OMemErr}); end
        vec++; if (Stall !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b want 0", Stall); end
        Reset = 1'b0;
        tick;
        vec++; if ({ORegWrite, OResult, ORd} !== {1'b1, 16'h1234, 16'd3}) begin errs++; $display("FAIL alu_pass: got %b %h %h want 1 1234 0003", ORegWrite, OResult, ORd); end
        vec++; if (Stall !== 1'b0) begin errs++; $display("FAIL alu_stall: got %b want 0", Stall); end
    endtask

    task automatic test_load;
        int r0 = nreq;
        drive(1, 1, 0, 0, 16'h0040, 16'h0, 16'd5);
        vec++; if (Stall !== 1'b1) begin errs++; $display("FAIL load_stall_idle: got %b want 1", Stall); end
        tick;
        vec++; if ({DmemReq, DmemWe, DmemAddr, ORegWrite} !== {1'b1, 1'b0, 16'h0040, 1'b0}) begin errs++; $display("FAIL load_issue: got %b %b %h %b want 1 0 0040 0", DmemReq, DmemWe, DmemAddr, ORegWrite); end
        for (int i = 0; i < 2; i++) begin
            tick;
            vec++; if ({Stall, DmemReq, ORegWrite} !== 3'b110) begin errs++; $display("FAIL load_wait%0d: got %b%b%b want 110", i, Stall, DmemReq, ORegWrite); end
        end
        DmemAck = 1'b1; DmemRData = 16'hBEEF;
        tick;
        DmemAck = 1'b0; DmemRData = 16'h0;
        #1;
        vec++; if ({DmemReq, ORegWrite, OResult, ORd, Stall} !== {1'b0, 1'b1, 16'hBEEF, 16'd5, 1'b0}) begin errs++; $display("FAIL load_done: got %b %b %h %h %b want 0 1 beef 0005 0", DmemReq, ORegWrite, OResult, ORd, Stall); end
        tick;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'd0);
        vec++; if ({DmemReq, ORegWrite, OMemErr} !== 3'b000) begin errs++; $display("FAIL load_after: got %b%b%b want 000", DmemReq, ORegWrite, OMemErr); end
        vec++; if (nreq - r0 !== 1) begin errs++; $display("FAIL load_issue_count: got %0d want 1", nreq - r0); end
        tick;
    endtask

    // Both read and write set: it must behave as a store.
    task automatic test_store;
        int h0 = nhigh;
        int stalls = 0;
        drive(1, 1, 1, 1, 16'h0010, 16'h5A5A, 16'd7);
        stalls += int'(Stall);
        tick;
        stalls += int'(Stall);
        vec++; if ({DmemReq, DmemWe, DmemAddr, DmemWData} !== {1'b1, 1'b1, 16'h0010, 16'h5A5A}) begin errs++; $display("FAIL store_issue: got %b %b %h %h want 1 1 0010 5a5a", DmemReq, DmemWe, DmemAddr, DmemWData); end
        DmemAck = 1'b1; DmemRData = 16'hFFFF;
        tick;
        DmemAck = 1'b0;
        #1;
        stalls += int'(Stall);
        vec++; if ({DmemReq, ORegWrite, ORegStore, OResult, ORd} !== {1'b0, 1'b1, 1'b1, 16'h0010, 16'd7}) begin errs++; $display("FAIL store_done: got %b %b %b %h %h want 0 1 1 0010 0007", DmemReq, ORegWrite, ORegStore, OResult, ORd); end
        vec++; if (stalls !== 2) begin errs++; $display("FAIL store_stall_cycles: got %0d want 2", stalls); end
        tick;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'd0);
        vec++; if (nhigh - h0 !== 1) begin errs++; $display("FAIL store_req_width: got %0d want 1", nhigh - h0); end
        tick;
    endtask

    task automatic test_back_to_back;
        int r0 = nreq;
        int q0 = alog.size();
        drive(1, 1, 0, 0, 16'h0002, 16'h0, 16'd1);
        tick;
        DmemAck = 1'b1; DmemRData = 16'h1111;
        tick;
        DmemAck = 1'b0;
        #1;
        vec++; if ({ORegWrite, OResult, ORd} !== {1'b1, 16'h1111, 16'd1}) begin errs++; $display("FAIL b2b_first: got %b %h %h want 1 1111 0001", ORegWrite, OResult, ORd); end
        tick;
        drive(1, 1, 0, 0, 16'h0004, 16'h0, 16'd2);
        vec++; if ({Stall, DmemReq} !== 2'b10) begin errs++; $display("FAIL b2b_gap: got %b%b want 10", Stall, DmemReq); end
        tick;
        DmemAck = 1'b1; DmemRData = 16'h2222;
        tick;
        DmemAck = 1'b0;
        #1;
        vec++; if ({ORegWrite, OResult, ORd} !== {1'b1, 16'h2222, 16'd2}) begin errs++; $display("FAIL b2b_second: got %b %h %h want 1 2222 0002", ORegWrite, OResult, ORd); end
        tick;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'd0);
        vec++; if (nreq - r0 !== 2) begin errs++; $display("FAIL b2b_issue_count: got %0d want 2", nreq - r0); end
        vec++; if (alog.size() < q0 + 2 || alog[q0] !== 16'h0002 || alog[q0 + 1] !== 16'h0004) begin errs++; $display("FAIL b2b_order: got %0d entries want 0002,0004", alog.size() - q0); end
        tick;
    endtask

    task automatic test_reset_mid;
        int r0 = nreq;
        drive(1, 1, 0, 0, 16'h0080, 16'h0, 16'd4);
        tick; tick;
        Reset = 1'b1;
        tick;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'd0);
        vec++; if ({DmemReq, ORegWrite, Stall} !== 3'b000) begin errs++; $display("FAIL midreset: got %b%b%b want 000", DmemReq, ORegWrite, Stall); end
        Reset = 1'b0; DmemAck = 1'b1; DmemRData = 16'hDEAD;
        tick; tick;
        DmemAck = 1'b0;
        vec++; if ({DmemReq, ORegWrite, OResult, Stall} !== {1'b0, 1'b0, 16'h0, 1'b0}) begin errs++; $display("FAIL late_ack: got %b %b %h %b want 0 0 0000 0", DmemReq, ORegWrite, OResult, Stall); end
        vec++; if (nreq - r0 !== 1) begin errs++; $display("FAIL midreset_issue_count: got %0d want 1", nreq - r0); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        int h0 = nhigh;
        drive(1, 1, 0, 0, 16'h0100, 16'h0, 16'd6);
        tick;
        for (int i = 0; i < 4; i++) tick;
        vec++; if ({DmemReq, OMemErr, ORegWrite, OResult, Stall} !== {1'b0, 1'b1, 1'b0, 16'h0, 1'b0}) begin errs++; $display("FAIL timeout_abort: got %b %b %b %h %b want 0 1 0 0000 0", DmemReq, OMemErr, ORegWrite, OResult, Stall); end
        vec++; if (nhigh - h0 !== 4) begin errs++; $display("FAIL timeout_req_cycles: got %0d want 4", nhigh - h0); end
        DmemAck = 1'b1; DmemRData = 16'hCAFE;
        tick;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'd0);
        vec++; if ({OMemErr, ORegWrite, DmemReq} !== 3'b000) begin errs++; $display("FAIL timeout_pulse: got %b%b%b want 000", OMemErr, ORegWrite, DmemReq); end
        DmemAck = 1'b0;
        tick;
    endtask
`else
    task automatic test_no_timeout;
        drive(1, 1, 0, 0, 16'h0100, 16'h0, 16'd6);
        for (int i = 0; i < 8; i++) tick;
        vec++; if ({DmemReq, Stall, OMemErr} !== 3'b110) begin errs++; $display("FAIL no_timeout_wait: got %b%b%b want 110", DmemReq, Stall, OMemErr); end
        DmemAck = 1'b1; DmemRData = 16'hCAFE;
        tick;
        DmemAck = 1'b0;
        #1;
        vec++; if ({ORegWrite, OResult, OMemErr} !== {1'b1, 16'hCAFE, 1'b0}) begin errs++; $display("FAIL no_timeout_done: got %b %h %b want 1 cafe 0", ORegWrite, OResult, OMemErr); end
        tick;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'd0);
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_load;
        test_store;
        test_back_to_back;
`ifdef MEM_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 16-bit pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its registered outputs.
- Performs data-memory loads and stores over a req/ack handshake. Stalls upstream stages while an access is outstanding.
- Produces registered MEM/WB-side outputs: write-back result, Rd, and control.

Parameters:
- DATA_W, 16, data and ALU result width.
- ADDR_W, 16, data-memory address width; address is ALUResult[ADDR_W-1:0].
- RD_W, 16, destination-register field width, passed through unchanged.
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with MEM_TIMEOUT_EN.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  reset; synchronous, active-high.
- IRegWrite  in  1  write-back enable from EX/MEM.
- IMemRead  in  1  load request.
- IMemWrite  in  1  store request.
- IRegStore  in  1  write-back source select, passed through.
- IALUResult  in  DATA_W  ALU result / memory address.
- I3rdArg  in  DATA_W  store data.
- IRd  in  RD_W  destination register.
- DmemReq  out  1  memory request, registered.
- DmemWe  out  1  1 = write, registered.
- DmemAddr  out  ADDR_W  registered address.
- DmemWData  out  DATA_W  registered store data.
- DmemRData  in  DATA_W  load data, valid when DmemAck=1.
- DmemAck  in  1  access complete.
- Stall  out  1  combinational; drives EX/MEM write-enable low and freezes upstream.
- ORegWrite  out  1  registered write-back enable.
- ORegStore  out  1  registered pass-through.
- OResult  out  DATA_W  load data for loads, else ALU result.
- ORd  out  RD_W  registered destination.
- OMemErr  out  1  one-cycle error pulse; tied 0 unless MEM_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, active-high) overrides everything, including mid-access. It forces state IDLE and drives 0 on DmemReq, DmemWe, DmemAddr, DmemWData, ORegWrite, ORegStore, OResult, ORd, OMemErr. Counter is cleared.
- State machine has three states: IDLE, REQ, DONE.
- IDLE, no memory op (IMemRead=0, IMemWrite=0):
  - Stall=0.
  - Next edge: ORegWrite<=IRegWrite, ORegStore<=IRegStore, OResult<=IALUResult, ORd<=IRd.
  - Latency is 1 cycle.
- IDLE, memory op:
  - Stall=1 combinationally in the same cycle.
  - Next edge: DmemReq<=1, DmemWe<=IMemWrite, DmemAddr<=IALUResult[ADDR_W-1:0], DmemWData<=I3rdArg.
  - Latch IRegWrite, IRegStore, IRd, IALUResult and an is_load flag internally.
  - Outputs become a bubble (ORegWrite=0). Go to REQ.
- IMemRead=1 and IMemWrite=1 together: write wins. Access is a store and OResult is the ALU result.
- REQ:
  - Stall=1. DmemReq held at 1; address, data and we held stable.
  - ORegWrite=0 each cycle.
  - DmemAck sampled at each edge. An ack on the first REQ cycle is legal (2-cycle memory op minimum).
  - On ack: DmemReq<=0. For a load, OResult<=DmemRData; for a store, OResult<=latched ALU result.
  - Also on ack: ORegWrite<=latched IRegWrite, ORegStore/ORd<=latched values. Go to DONE.
- DONE:
  - Stall=0, so EX/MEM advances at this edge.
  - The still-held instruction at the inputs is not re-issued. Inputs are ignored this cycle.
  - Outputs hold the completed result for this one cycle. Next edge: ORegWrite<=0, go to IDLE.
- DmemAck is ignored in IDLE and DONE.
- A memory op therefore costs (1 + ack wait + 1) cycles. Back-to-back memory ops both stall and are both issued, with no loss.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and clears on entry.
  - If it reaches TIMEOUT_CYCLES with no ack: DmemReq<=0, OMemErr<=1 for the DONE cycle, ORegWrite forced 0, OResult<=0. Go to DONE.
  - A late ack after abort is ignored.
- Undefined: REQ waits indefinitely and OMemErr is constant 0.

Test Plan:
- Reset high for 2 cycles, then low, with ALU op IRegWrite=1, IALUResult=16'h1234, IRd=3 -> all outputs 0 during reset. One cycle later ORegWrite=1, OResult=16'h1234, ORd=3, Stall=0 throughout.
- Load IMemRead=1, IALUResult=16'h0040, DmemAck returned 3 cycles after DmemReq rises with DmemRData=16'hBEEF -> DmemAddr=16'h0040, DmemWe=0. Stall=1 until ack edge. DONE cycle shows OResult=16'hBEEF, ORegWrite=1. Request issued exactly once.
- Store IMemWrite=1, I3rdArg=16'h5A5A, IALUResult=16'h0010, ack on first REQ cycle -> DmemWe=1, DmemWData=16'h5A5A, DmemReq high exactly 1 cycle. Total stall is 2 cycles.
- Two back-to-back loads (addr 16'h0002, then 16'h0004) -> two distinct requests in order, no duplicate issue of the first load, both results written back.
- Reset asserted while in REQ -> next edge DmemReq=0, state IDLE, ORegWrite=0. A later ack has no effect.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with no ack -> DmemReq drops after 4 REQ cycles, OMemErr=1 for one cycle, ORegWrite=0, Stall releases.
